// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter sharing one FPU among NUM_REQ requesters, with per-requester in-flight
// limits, a one-entry response buffer toward the requesters and a drain mode.
module fpu_share_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned FLEN            = 64,
    parameter int unsigned MAX_OUTSTANDING = 3,
    localparam int unsigned TAG_WIDTH      = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*3*FLEN-1:0] req_operands_i,
    input  logic [NUM_REQ*4-1:0]      req_op_i,
    input  logic [NUM_REQ-1:0]        req_op_mod_i,
    input  logic [NUM_REQ*3-1:0]      req_rnd_mode_i,
    output logic [3*FLEN-1:0]         fpu_operands_o,
    output logic [3:0]                fpu_op_o,
    output logic                      fpu_op_mod_o,
    output logic [2:0]                fpu_rnd_mode_o,
    output logic [TAG_WIDTH-1:0]      fpu_tag_o,
    output logic                      fpu_in_valid_o,
    input  logic                      fpu_in_ready_i,
    input  logic [FLEN-1:0]           fpu_result_i,
    input  logic [4:0]                fpu_status_i,
    input  logic [TAG_WIDTH-1:0]      fpu_tag_i,
    input  logic                      fpu_out_valid_i,
    output logic                      fpu_out_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    input  logic [NUM_REQ-1:0]        rsp_ready_i,
    output logic [FLEN-1:0]           rsp_result_o,
    output logic [4:0]                rsp_status_o,
    input  logic                      drain_i,
    output logic                      drained_o
);

    localparam int unsigned CNT_W = (TAG_WIDTH + 1 > 3) ? TAG_WIDTH + 1 : 3;

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e               state_q;
    logic [TAG_WIDTH-1:0] last_grant_q;
    logic                 hold_q;
    logic [TAG_WIDTH-1:0] hold_tag_q;
    logic [CNT_W-1:0]     cnt_q [NUM_REQ];
    logic [CNT_W-1:0]     cnt_d [NUM_REQ];
    logic                 buf_valid_q;
    logic                 buf_valid_d;
    logic [TAG_WIDTH-1:0] buf_tag_q;
    logic [FLEN-1:0]      buf_result_q;
    logic [4:0]           buf_status_q;
    logic                 drained_q;

    logic [NUM_REQ-1:0]   eligible;
    logic [TAG_WIDTH-1:0] grant;
    logic [TAG_WIDTH-1:0] rr_idx;
    logic                 grant_found;
    logic                 issue;
    logic                 rsp_accept;
    logic                 capture;
    logic                 drain_empty;
    logic [NUM_REQ-1:0]   cnt_inc;
    logic [NUM_REQ-1:0]   cnt_dec;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING)) &&
                          (state_q == StRun) && !rst_i;
        end
    end

    // A stalled grant is kept while its requester stays eligible; otherwise round-robin
    // starting just after the last accepted grant.
    always_comb begin
        grant       = last_grant_q;
        grant_found = 1'b0;
        rr_idx      = '0;
        if (hold_q && eligible[hold_tag_q]) begin
            grant       = hold_tag_q;
            grant_found = 1'b1;
        end
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_idx = last_grant_q + TAG_WIDTH'(k);
            if (!grant_found && eligible[rr_idx]) begin
                grant       = rr_idx;
                grant_found = 1'b1;
            end
        end
    end

    assign fpu_in_valid_o = |eligible;
    assign issue          = fpu_in_valid_o & fpu_in_ready_i;
    assign fpu_tag_o      = grant;
    assign fpu_operands_o = req_operands_i[32'(grant) * 3 * FLEN +: 3 * FLEN];
    assign fpu_op_o       = req_op_i[32'(grant) * 4 +: 4];
    assign fpu_op_mod_o   = req_op_mod_i[grant];
    assign fpu_rnd_mode_o = req_rnd_mode_i[32'(grant) * 3 +: 3];

    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = fpu_in_valid_o & fpu_in_ready_i;
    end

    assign rsp_accept      = buf_valid_q & rsp_ready_i[buf_tag_q];
    assign fpu_out_ready_o = ~rst_i & (~buf_valid_q | rsp_ready_i[buf_tag_q]);
    assign capture         = fpu_out_valid_i & fpu_out_ready_o;
    assign buf_valid_d     = capture | (buf_valid_q & ~rsp_accept);
    assign rsp_result_o    = buf_result_q;
    assign rsp_status_o    = buf_status_q;
    assign drained_o       = drained_q;

    always_comb begin
        rsp_valid_o = '0;
        if (buf_valid_q && !rst_i) begin
            rsp_valid_o[buf_tag_q] = 1'b1;
        end
    end

    // A response for an idle requester still passes through but never underflows its count.
    always_comb begin
        drain_empty = ~buf_valid_d;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_inc[i] = issue && (grant == TAG_WIDTH'(i));
            cnt_dec[i] = rsp_accept && (buf_tag_q == TAG_WIDTH'(i));
            cnt_d[i]   = cnt_q[i];
            if (cnt_inc[i] && !cnt_dec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (cnt_dec[i] && !cnt_inc[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (cnt_d[i] != '0) begin
                drain_empty = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StRun;
            last_grant_q <= TAG_WIDTH'(NUM_REQ - 1);
            hold_q       <= 1'b0;
            hold_tag_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
            buf_valid_q  <= 1'b0;
            buf_tag_q    <= '0;
            buf_result_q <= '0;
            buf_status_q <= '0;
            drained_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (issue) begin
                last_grant_q <= grant;
            end
            hold_q      <= fpu_in_valid_o & ~fpu_in_ready_i;
            hold_tag_q  <= grant;
            buf_valid_q <= buf_valid_d;
            if (capture) begin
                buf_tag_q    <= fpu_tag_i;
                buf_result_q <= fpu_result_i;
                buf_status_q <= fpu_status_i;
            end
            drained_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (drain_i) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_empty) begin
                        state_q   <= StRun;
                        drained_q <= 1'b1;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: directed vector table, hand-written multi-cycle sequences and a
// randomized run against a queue-based reference model.
module tb_fpu_share_arbiter;

    localparam int NR = 4;
    localparam int FL = 64;
    localparam int MO = 3;
    localparam int TW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*3*FL-1:0] req_operands;
    logic [NR*4-1:0]   req_op;
    logic [NR-1:0]     req_op_mod;
    logic [NR*3-1:0]   req_rnd_mode;
    logic [3*FL-1:0]   fpu_operands;
    logic [3:0]        fpu_op;
    logic              fpu_op_mod;
    logic [2:0]        fpu_rnd_mode;
    logic [TW-1:0]     fpu_tag;
    logic              fpu_in_valid, fpu_in_ready;
    logic [FL-1:0]     fpu_result;
    logic [4:0]        fpu_status;
    logic [TW-1:0]     fpu_tag_in;
    logic              fpu_out_valid, fpu_out_ready;
    logic [NR-1:0]     rsp_valid, rsp_ready;
    logic [FL-1:0]     rsp_result;
    logic [4:0]        rsp_status;
    logic              drain, drained;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fpu_share_arbiter #(.NUM_REQ(NR), .FLEN(FL), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operands_i(req_operands), .req_op_i(req_op), .req_op_mod_i(req_op_mod),
        .req_rnd_mode_i(req_rnd_mode),
        .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod),
        .fpu_rnd_mode_o(fpu_rnd_mode), .fpu_tag_o(fpu_tag),
        .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
        .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
        .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
        .drain_i(drain), .drained_o(drained)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_wide(input string name, input logic [3*FL-1:0] act,
                            input logic [3*FL-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        req_valid     = '0;
        fpu_in_ready  = 1'b1;
        fpu_out_valid = 1'b0;
        fpu_result    = '0;
        fpu_status    = '0;
        fpu_tag_in    = '0;
        rsp_ready     = '1;
        drain         = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_fixed_fields();
        for (int i = 0; i < NR; i++) begin
            req_op[i*4 +: 4]       = 4'(i + 5);
            req_op_mod[i]          = 1'(i % 2);
            req_rnd_mode[i*3 +: 3] = 3'(i + 1);
            for (int j = 0; j < 3; j++) begin
                req_operands[(i*3 + j)*FL +: FL] = 64'(64'h1000 * (i + 1) + j);
            end
        end
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic          in_ready;
        logic          exp_in_valid;
        logic [TW-1:0] exp_tag;
        logic [NR-1:0] exp_req_ready;
    } vec_t;

    vec_t tbl[13];

    typedef struct {
        logic [TW-1:0] tag;
        logic [FL-1:0] res;
        logic [4:0]    st;
    } op_t;

    // Reference model state for the randomized run
    op_t           fq[$];
    op_t           op;
    int            m_cnt[NR];
    int            m_last, m_stall, g;
    bit            m_drain, m_drained, all0;
    bit            mb_valid;
    int            mb_tag;
    logic [FL-1:0] mb_res;
    logic [4:0]    mb_st;
    logic [NR-1:0] pend, elig, e_rr, e_rv;
    bit            e_in_valid, e_issue, e_out_ready, e_rsp_acc, e_cap;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[6]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
        tbl[7]  = '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[8]  = '{4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[9]  = '{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[10] = '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[11] = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[12] = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};

        set_fixed_fields();
        quiet_inputs();

        // Outputs held low during reset even with traffic present
        rst = 1'b1;
        next_cycle();
        req_valid     = '1;
        fpu_out_valid = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_in_valid", 64'(fpu_in_valid), 64'h0);
        chk("rst_out_ready", 64'(fpu_out_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        next_cycle();
        rst = 1'b0;
        quiet_inputs();
        @(negedge clk);
        chk("post_rst_drained", 64'(drained), 64'h0);
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        next_cycle();

        // Issue-path vector table
        for (int v = 0; v < 13; v++) begin
            req_valid    = tbl[v].valid;
            fpu_in_ready = tbl[v].in_ready;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_valid", v), 64'(fpu_in_valid), 64'(tbl[v].exp_in_valid));
            chk($sformatf("tbl%0d_req_ready", v), 64'(req_ready), 64'(tbl[v].exp_req_ready));
            if (tbl[v].exp_in_valid) begin
                chk($sformatf("tbl%0d_tag", v), 64'(fpu_tag), 64'(tbl[v].exp_tag));
                chk($sformatf("tbl%0d_op", v), 64'(fpu_op), 64'(tbl[v].exp_tag + 5));
                chk($sformatf("tbl%0d_rnd", v), 64'(fpu_rnd_mode), 64'(tbl[v].exp_tag + 1));
                chk_wide($sformatf("tbl%0d_operands", v), fpu_operands,
                         req_operands[32'(tbl[v].exp_tag)*3*FL +: 3*FL]);
            end
            next_cycle();
        end

        // In-flight limit with responses withheld from requester 1
        do_reset();
        req_valid = 4'b0010;
        rsp_ready = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lim_issue_ready", 64'(req_ready), 64'b0010);
            chk("lim_issue_tag", 64'(fpu_tag), 64'd1);
            next_cycle();
        end
        fpu_out_valid = 1'b1;
        fpu_tag_in    = 2'd1;
        fpu_result    = 64'hBEEF;
        fpu_status    = 5'h03;
        @(negedge clk);
        chk("lim_full_ready", 64'(req_ready), 64'h0);
        chk("lim_full_in_valid", 64'(fpu_in_valid), 64'h0);
        chk("lim_out_ready", 64'(fpu_out_ready), 64'h1);
        next_cycle();
        fpu_out_valid = 1'b0;
        @(negedge clk);
        chk("lim_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("lim_rsp_result", 64'(rsp_result), 64'hBEEF);
        chk("lim_rsp_status", 64'(rsp_status), 64'h03);
        chk("lim_still_full", 64'(req_ready), 64'h0);
        next_cycle();
        rsp_ready = '1;
        @(negedge clk);
        chk("lim_accept_cycle_ready", 64'(req_ready), 64'h0);
        chk("lim_held_rsp", 64'(rsp_valid), 64'b0010);
        next_cycle();
        @(negedge clk);
        chk("lim_rsp_gone", 64'(rsp_valid), 64'h0);
        chk("lim_ready_again", 64'(req_ready), 64'b0010);
        next_cycle();

        // Grant held through an FPU input stall, even when a higher-priority requester rises
        do_reset();
        req_valid    = 4'b1100;
        fpu_in_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) req_valid = 4'b1101;
            @(negedge clk);
            chk("stall_in_valid", 64'(fpu_in_valid), 64'h1);
            chk("stall_tag", 64'(fpu_tag), 64'd2);
            chk("stall_req_ready", 64'(req_ready), 64'h0);
            next_cycle();
        end
        fpu_in_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_tag", 64'(fpu_tag), 64'd2);
        chk("stall_release_ready", 64'(req_ready), 64'b0100);
        next_cycle();
        req_valid = 4'b1001;
        @(negedge clk);
        chk("stall_after_tag", 64'(fpu_tag), 64'd3);
        chk("stall_after_ready", 64'(req_ready), 64'b1000);
        next_cycle();

        // Back-to-back results for tags 3 then 0, both with no issue outstanding
        do_reset();
        fpu_out_valid = 1'b1;
        fpu_tag_in    = 2'd3;
        fpu_result    = 64'h3333;
        fpu_status    = 5'h13;
        @(negedge clk);
        chk("b2b_out_ready0", 64'(fpu_out_ready), 64'h1);
        chk("b2b_rsp_none", 64'(rsp_valid), 64'h0);
        next_cycle();
        fpu_tag_in = 2'd0;
        fpu_result = 64'hAAAA;
        fpu_status = 5'h01;
        @(negedge clk);
        chk("b2b_out_ready1", 64'(fpu_out_ready), 64'h1);
        chk("b2b_rsp3", 64'(rsp_valid), 64'b1000);
        chk("b2b_res3", 64'(rsp_result), 64'h3333);
        chk("b2b_st3", 64'(rsp_status), 64'h13);
        next_cycle();
        fpu_out_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_ready2", 64'(fpu_out_ready), 64'h1);
        chk("b2b_rsp0", 64'(rsp_valid), 64'b0001);
        chk("b2b_res0", 64'(rsp_result), 64'hAAAA);
        chk("b2b_st0", 64'(rsp_status), 64'h01);
        next_cycle();
        // Counters must not have wrapped below zero: requester 3 gets exactly MO issues
        req_valid = 4'b1000;
        rsp_ready = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("b2b_rsp_clear", 64'(rsp_valid), 64'h0);
            chk($sformatf("nounderflow_ready%0d", k), 64'(req_ready),
                (k < MO) ? 64'b1000 : 64'h0);
            next_cycle();
        end

        // Drain with two operations in flight
        do_reset();
        req_valid = 4'b0011;
        @(negedge clk);
        chk("drain_issue0", 64'(fpu_tag), 64'd0);
        next_cycle();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("drain_issue1", 64'(fpu_tag), 64'd1);
        next_cycle();
        req_valid    = 4'b1111;
        fpu_in_ready = 1'b0;
        drain        = 1'b1;
        @(negedge clk);
        chk("drain_d0_drained", 64'(drained), 64'h0);
        next_cycle();
        drain         = 1'b0;
        fpu_in_ready  = 1'b1;
        fpu_out_valid = 1'b1;
        fpu_tag_in    = 2'd0;
        fpu_result    = 64'h10;
        @(negedge clk);
        chk("drain_d1_noissue", 64'(fpu_in_valid), 64'h0);
        chk("drain_d1_ready", 64'(req_ready), 64'h0);
        next_cycle();
        fpu_tag_in = 2'd1;
        fpu_result = 64'h11;
        @(negedge clk);
        chk("drain_d2_noissue", 64'(fpu_in_valid), 64'h0);
        chk("drain_d2_rsp", 64'(rsp_valid), 64'b0001);
        next_cycle();
        fpu_out_valid = 1'b0;
        @(negedge clk);
        chk("drain_d3_noissue", 64'(fpu_in_valid), 64'h0);
        chk("drain_d3_rsp", 64'(rsp_valid), 64'b0010);
        chk("drain_d3_drained", 64'(drained), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("drain_d4_drained", 64'(drained), 64'h1);
        chk("drain_d4_resume", 64'(fpu_in_valid), 64'h1);
        chk("drain_d4_tag", 64'(fpu_tag), 64'd2);
        next_cycle();
        @(negedge clk);
        chk("drain_d5_drained", 64'(drained), 64'h0);
        chk("drain_d5_tag", 64'(fpu_tag), 64'd3);
        next_cycle();

        // Reset while requester 0 has two in flight and a response is buffered
        do_reset();
        req_valid = 4'b0001;
        rsp_ready = '0;
        next_cycle();
        next_cycle();
        req_valid     = '0;
        fpu_out_valid = 1'b1;
        fpu_tag_in    = 2'd0;
        next_cycle();
        fpu_out_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_buf", 64'(rsp_valid), 64'b0001);
        rst = 1'b1;
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_mid_rsp", 64'(rsp_valid), 64'h0);
        chk("rst_mid_tag", 64'(fpu_tag), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'b0001);
        next_cycle();
        req_valid = 4'b0001;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_cnt%0d", k), 64'(req_ready), (k < MO) ? 64'b0001 : 64'h0);
            next_cycle();
        end

        // Randomized traffic against the reference model
        do_reset();
        fq.delete();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_last    = NR - 1;
        m_stall   = -1;
        m_drain   = 1'b0;
        m_drained = 1'b0;
        mb_valid  = 1'b0;
        mb_tag    = 0;
        mb_res    = '0;
        mb_st     = '0;
        pend      = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) pend[i] = ($urandom_range(0, 1) == 1);
                req_op[i*4 +: 4]       = 4'($urandom());
                req_op_mod[i]          = 1'($urandom());
                req_rnd_mode[i*3 +: 3] = 3'($urandom());
                rsp_ready[i]           = ($urandom_range(0, 9) < 7);
            end
            for (int j = 0; j < NR*3*FL/32; j++) req_operands[j*32 +: 32] = $urandom();
            req_valid     = pend;
            fpu_in_ready  = ($urandom_range(0, 3) != 0);
            fpu_out_valid = (fq.size() > 0) && ($urandom_range(0, 2) != 0);
            if (fpu_out_valid) begin
                fpu_tag_in = fq[0].tag;
                fpu_result = fq[0].res;
                fpu_status = fq[0].st;
            end else begin
                fpu_tag_in = TW'($urandom());
                fpu_result = {$urandom(), $urandom()};
                fpu_status = 5'($urandom());
            end
            drain = !m_drain && ($urandom_range(0, 49) == 0);

            for (int i = 0; i < NR; i++) elig[i] = pend[i] && (m_cnt[i] < MO) && !m_drain;
            g = -1;
            if (m_stall >= 0 && elig[m_stall]) g = m_stall;
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && elig[(m_last + k) % NR]) g = (m_last + k) % NR;
            end
            e_in_valid  = (g >= 0);
            e_issue     = e_in_valid && fpu_in_ready;
            e_rr        = e_issue ? NR'(1 << g) : '0;
            e_out_ready = !mb_valid || rsp_ready[mb_tag];
            e_rsp_acc   = mb_valid && rsp_ready[mb_tag];
            e_cap       = fpu_out_valid && e_out_ready;
            e_rv        = mb_valid ? NR'(1 << mb_tag) : '0;

            @(negedge clk);
            chk("rnd_in_valid", 64'(fpu_in_valid), 64'(e_in_valid));
            chk("rnd_req_ready", 64'(req_ready), 64'(e_rr));
            if (e_in_valid) begin
                chk("rnd_tag", 64'(fpu_tag), 64'(g));
                chk("rnd_op", 64'({fpu_op_mod, fpu_rnd_mode, fpu_op}),
                    64'({req_op_mod[g], req_rnd_mode[g*3 +: 3], req_op[g*4 +: 4]}));
                chk_wide("rnd_operands", fpu_operands, req_operands[g*3*FL +: 3*FL]);
            end
            chk("rnd_out_ready", 64'(fpu_out_ready), 64'(e_out_ready));
            chk("rnd_rsp_valid", 64'(rsp_valid), 64'(e_rv));
            if (mb_valid) begin
                chk("rnd_rsp_result", 64'(rsp_result), 64'(mb_res));
                chk("rnd_rsp_status", 64'(rsp_status), 64'(mb_st));
            end
            chk("rnd_drained", 64'(drained), 64'(m_drained));

            m_stall = (e_in_valid && !fpu_in_ready) ? g : -1;
            if (e_rsp_acc) begin
                m_cnt[mb_tag]--;
                mb_valid = 1'b0;
            end
            if (e_cap) begin
                op       = fq.pop_front();
                mb_valid = 1'b1;
                mb_tag   = int'(op.tag);
                mb_res   = op.res;
                mb_st    = op.st;
            end
            if (e_issue) begin
                m_cnt[g]++;
                m_last  = g;
                pend[g] = 1'b0;
                op.tag  = TW'(g);
                op.res  = {$urandom(), $urandom()};
                op.st   = 5'($urandom());
                fq.push_back(op);
            end
            m_drained = 1'b0;
            if (!m_drain) begin
                if (drain) m_drain = 1'b1;
            end else begin
                all0 = !mb_valid;
                for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) all0 = 1'b0;
                if (all0) begin
                    m_drain   = 1'b0;
                    m_drained = 1'b1;
                end
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_share_arbiter.md
FPU_SHARE_ARBITER -- requirements
Module: fpu_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (power of two, 2..8).
REQ-002 SHALL have parameter FLEN, default 64, giving the operand and result width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 3, giving the per-requester in-flight limit (1..7).
REQ-004 SHALL derive TAG_WIDTH = log2(NUM_REQ).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have these ports (name  direction  width  meaning):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i / req_ready_o  in/out  NUM_REQ  per-requester issue handshake.
- req_operands_i  in  NUM_REQ*3*FLEN  three operands per requester.
- req_op_i  in  NUM_REQ*4  FPU operation per requester.
- req_op_mod_i  in  NUM_REQ  op modifier.
- req_rnd_mode_i  in  NUM_REQ*3  rounding mode.
- fpu_operands_o  out  3*FLEN  operands to FPU.
- fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o  out  4/1/3  operation, modifier, rounding mode to FPU.
- fpu_tag_o  out  TAG_WIDTH  granted requester index.
- fpu_in_valid_o / fpu_in_ready_i  out/in  1  FPU input handshake.
- fpu_result_i  in  FLEN  FPU result.
- fpu_status_i  in  5  FPU status flags.
- fpu_tag_i  in  TAG_WIDTH  returned tag.
- fpu_out_valid_i / fpu_out_ready_o  in/out  1  FPU output handshake.
- rsp_valid_o / rsp_ready_i  out/in  NUM_REQ  per-requester response handshake.
- rsp_result_o  out  FLEN  shared response result.
- rsp_status_o  out  5  shared response status flags.
- drain_i  in  1  stop issuing and empty the FPU.
- drained_o  out  1  one-cycle pulse when the drain completes.

Function
REQ-007 SHALL grant among eligible requesters round-robin; eligible means req_valid_i[i]=1, cnt[i]<MAX_OUTSTANDING, and state=RUN.
REQ-008 SHALL give highest priority to index (last_grant+1) mod NUM_REQ; SHALL update last_grant only on an accepted issue.
REQ-009 SHALL drive the issue path combinationally:
- fpu_in_valid_o = any eligible requester.
- fpu_* outputs = the granted requester's fields; fpu_tag_o = its index.
- req_ready_o[g] = fpu_in_ready_i for the granted index g; 0 for all others.
REQ-010 SHALL NOT change the grant while fpu_in_valid_o=1 and fpu_in_ready_i=0.
REQ-011 SHALL keep a (TAG_WIDTH+1)-bit-or-wider counter cnt[i] per requester:
- +1 on an accepted issue from i.
- -1 on an accepted response to i.
- Unchanged when both occur in the same cycle.
REQ-012 SHALL capture FPU results into a one-entry response register (valid, tag, result, status) on fpu_out_valid_i & fpu_out_ready_o.
REQ-013 SHALL drive fpu_out_ready_o = ~buf_valid | rsp_ready_i[buf_tag], giving back-to-back throughput of one per cycle.
REQ-014 SHALL drive rsp_valid_o = one-hot(buf_tag) when buf_valid=1, else 0; rsp_result_o and rsp_status_o come from the buffer.
REQ-015 SHALL hold buffer contents stable while rsp_valid_o[buf_tag]=1 and rsp_ready_i[buf_tag]=0.
REQ-016 SHALL give one-cycle minimum latency from FPU output handshake to rsp_valid_o.
REQ-017 SHALL implement FSM RUN, DRAIN:
- RUN -> DRAIN when drain_i=1; any issue handshake in that same cycle still completes.
- DRAIN: no grants; stays until all cnt=0 and buf_valid=0.
- DRAIN -> RUN when empty; drained_o=1 for exactly that transition cycle.
- drain_i asserted while already in DRAIN is ignored.
REQ-018 SHALL pass a response whose tag has cnt=0 to the requester and SHALL NOT decrement below 0.

Reset
REQ-019 SHALL, on rst_i=1 at a clock edge, set:
- all cnt=0, last_grant=NUM_REQ-1 (requester 0 first), buf_valid=0, state=RUN, drained_o=0.
REQ-020 SHALL hold req_ready_o, fpu_in_valid_o, fpu_out_ready_o, and rsp_valid_o at 0 while rst_i=1.
REQ-021 SHALL, on reset mid-operation, discard in-flight responses; the bench also resets the FPU.

Verification
REQ-022 SHALL be tested with requesters 0..3 all valid and the FPU always ready -> issue tags 0,1,2,3,0 on five consecutive cycles.
REQ-023 SHALL be tested with requester 1 alone issuing and its responses withheld (rsp_ready_i[1]=0) -> exactly 3 issues, then req_ready_o[1]=0 until one response is accepted.
REQ-024 SHALL be tested with fpu_in_ready_i=0 for 4 cycles while requesters 2 and 3 are valid -> grant stays at 2; tag 2 issues when ready rises.
REQ-025 SHALL be tested with results tagged 3 then 0 back-to-back and rsp_ready_i=all 1 -> rsp_valid_o=1000 then 0001 on consecutive cycles, fpu_out_ready_o constant 1.
REQ-026 SHALL be tested with drain_i pulsed while 2 ops are in flight -> no new issues; drained_o pulses one cycle after the last response is accepted; then issuing resumes.
REQ-027 SHALL be tested with rst_i asserted while cnt[0]=2 and buf_valid=1 -> the next cycle has all counters 0, rsp_valid_o=0, and requester 0 granted first.
